// File: rtl/a2d_arbiter.sv
// Round-robin arbiter sharing one A2D converter between three requesters.
// Optional conversion timeout enabled by defining A2D_ARB_TIMEOUT_EN.
module a2d_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [8:0]  chnl_in,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [2:0]  err,
    output logic [11:0] rd_data,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("a2d_arbiter: TIMEOUT must be in 1..1023");
    end

    logic [1:0] state;
    logic [1:0] last;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic [1:0] cur;
    logic [2:0] sel_chnl;

    // Search starts one past the last served requester, wrapping mod 3.
    always_comb begin
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(last) + 1 + k) % 3);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    sel_chnl = chnl_in[2:0];
            2'd1:    sel_chnl = chnl_in[5:3];
            default: sel_chnl = chnl_in[8:6];
        endcase
    end

    always_comb begin
        cur = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);
    end

    assign strt_cnv = (state == START);

`ifdef A2D_ARB_TIMEOUT_EN
    logic [9:0] cnt;
    logic       tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state == START)
            cnt <= '0;
        else if (state == WAIT)
            cnt <= cnt + 10'd1;
    end

    assign tmo = (state == WAIT) && (cnt == 10'(TIMEOUT - 1));
`else
    assign err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            rd_data <= '0;
            chnnl   <= '0;
            last    <= 2'd2;
`ifdef A2D_ARB_TIMEOUT_EN
            err     <= '0;
`endif
        end else begin
            done <= '0;
`ifdef A2D_ARB_TIMEOUT_EN
            err  <= '0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= 3'b001 << win;
                        chnnl <= sel_chnl;
                        state <= START;
                    end
                end
                // A complete seen here belongs to an earlier conversion.
                START: state <= WAIT;
                WAIT: begin
                    if (cnv_cmplt) begin
                        rd_data <= res;
                        done    <= gnt;
                        gnt     <= '0;
                        last    <= cur;
                        state   <= IDLE;
                    end
`ifdef A2D_ARB_TIMEOUT_EN
                    else if (tmo) begin
                        err   <= gnt;
                        gnt   <= '0;
                        last  <= cur;
                        state <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_arbiter.sv
// Directed bench for a2d_arbiter: reset, single, round-robin, stale complete,
// mid-WAIT reset, dropped request and (with A2D_ARB_TIMEOUT_EN) timeout.
module tb_a2d_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [8:0]  chnl_in;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [11:0] rd_data;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;

    int checks = 0;
    int errors = 0;

    a2d_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .chnl_in(chnl_in),
        .gnt(gnt), .done(done), .err(err), .rd_data(rd_data),
        .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        cnv_cmplt = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Waits for a grant, then plays the converter: completes lat cycles later.
    task automatic serve(input logic [11:0] data, input int lat,
                         output logic [2:0] g, output logic [2:0] ch,
                         output logic [2:0] d, output logic [11:0] rd,
                         output int nstrt, output logic timed_out);
        int n;
        nstrt = 0;
        n = 0;
        while (gnt == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        timed_out = (gnt == 3'b000);
        g = gnt;
        ch = chnnl;
        if (strt_cnv) nstrt++;
        repeat (lat) begin
            tick();
            if (strt_cnv) nstrt++;
        end
        cnv_cmplt = 1'b1;
        res = data;
        tick();
        cnv_cmplt = 1'b0;
        d = done;
        rd = rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        chnl_in = '0;
        cnv_cmplt = 1'b0;
        res = '0;
        tick();
        tick();
        checks++;
        if ({gnt, done, err, chnnl, strt_cnv} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctrl got gnt=%b done=%b err=%b chnnl=%0d strt=%b want all 0",
                     gnt, done, err, chnnl, strt_cnv);
        end
        checks++;
        if (rd_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 000", rd_data);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (gnt !== 3'b000 || strt_cnv !== 1'b0 || err !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_req got gnt=%b strt=%b err=%b want 000/0/000", gnt, strt_cnv, err);
        end
    endtask

    task automatic test_single();
        logic [2:0] g, ch, d;
        logic [11:0] rd;
        int ns;
        logic to;
        chnl_in = {3'd0, 3'd0, 3'd4};
        req = 3'b001;
        tick();
        checks++;
        if (gnt !== 3'b001 || chnnl !== 3'd4 || strt_cnv !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got gnt=%b chnnl=%0d strt=%b want 001/4/1", gnt, chnnl, strt_cnv);
        end
        serve(12'hABC, 40, g, ch, d, rd, ns, to);
        req = 3'b000;
        checks++;
        if (ns != 1) begin
            errors++;
            $display("FAIL single_strt_pulses got %0d want 1", ns);
        end
        checks++;
        if (d !== 3'b001 || rd !== 12'hABC || gnt !== 3'b000) begin
            errors++;
            $display("FAIL single_done got done=%b rd=%h gnt=%b want 001/abc/000", d, rd, gnt);
        end
        tick();
        checks++;
        if (done !== 3'b000 || rd_data !== 12'hABC) begin
            errors++;
            $display("FAIL single_done_width got done=%b rd=%h want 000/abc", done, rd_data);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] g, ch, d;
        logic [11:0] rd;
        int ns;
        logic to;
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [2:0] exp_c [6] = '{3'd3, 3'd5, 3'd6, 3'd3, 3'd5, 3'd6};
        do_reset();
        chnl_in = {3'd6, 3'd5, 3'd3};
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            serve(12'(12'h100 + i), 3 + i, g, ch, d, rd, ns, to);
            checks++;
            if (to || g !== exp_g[i] || ch !== exp_c[i] || d !== exp_g[i] || rd !== 12'(12'h100 + i)) begin
                errors++;
                $display("FAIL rr_%0d got gnt=%b ch=%0d done=%b rd=%h want %b/%0d/%b/%h",
                         i, g, ch, d, rd, exp_g[i], exp_c[i], exp_g[i], 12'(12'h100 + i));
            end
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_stale_complete();
        int ndone;
        chnl_in = {3'd0, 3'd0, 3'd2};
        req = 3'b001;
        tick();
        cnv_cmplt = 1'b1;
        res = 12'hBAD;
        tick();
        cnv_cmplt = 1'b0;
        ndone = 0;
        repeat (5) begin
            tick();
            if (done != 3'b000) ndone++;
        end
        checks++;
        if (ndone != 0 || gnt !== 3'b001 || rd_data === 12'hBAD) begin
            errors++;
            $display("FAIL stale_ignored got done_pulses=%0d gnt=%b rd=%h want 0/001/not bad",
                     ndone, gnt, rd_data);
        end
        cnv_cmplt = 1'b1;
        res = 12'h123;
        tick();
        cnv_cmplt = 1'b0;
        req = 3'b000;
        if (done != 3'b000) ndone++;
        checks++;
        if (done !== 3'b001 || rd_data !== 12'h123) begin
            errors++;
            $display("FAIL stale_real_done got done=%b rd=%h want 001/123", done, rd_data);
        end
        repeat (3) begin
            tick();
            if (done != 3'b000) ndone++;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL stale_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [2:0] g, ch, d;
        logic [11:0] rd;
        int ns;
        logic to;
        chnl_in = {3'd0, 3'd7, 3'd1};
        req = 3'b001;
        tick();
        repeat (21) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, chnnl, strt_cnv} !== 13'd0 || rd_data !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_wait got gnt=%b done=%b err=%b ch=%0d strt=%b rd=%h want 0",
                     gnt, done, err, chnnl, strt_cnv, rd_data);
        end
        tick();
        rst_n = 1'b1;
        req = 3'b010;
        serve(12'h456, 4, g, ch, d, rd, ns, to);
        req = 3'b000;
        checks++;
        if (to || g !== 3'b010 || ch !== 3'd7 || d !== 3'b010 || rd !== 12'h456) begin
            errors++;
            $display("FAIL rst_then_req1 got gnt=%b ch=%0d done=%b rd=%h want 010/7/010/456", g, ch, d, rd);
        end
        tick();
    endtask

    task automatic test_req_drop();
        int extra;
        chnl_in = {3'd6, 3'd0, 3'd0};
        req = 3'b100;
        tick();
        tick();
        tick();
        req = 3'b000;
        repeat (3) tick();
        cnv_cmplt = 1'b1;
        res = 12'h789;
        tick();
        cnv_cmplt = 1'b0;
        checks++;
        if (done !== 3'b100 || rd_data !== 12'h789 || chnnl !== 3'd6) begin
            errors++;
            $display("FAIL drop_done got done=%b rd=%h ch=%0d want 100/789/6", done, rd_data, chnnl);
        end
        extra = 0;
        repeat (5) begin
            tick();
            if (gnt != 3'b000 || strt_cnv) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL drop_no_regrant got %0d busy cycles want 0", extra);
        end
    endtask

`ifdef A2D_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        logic [11:0] rd_before;
        int ndone;
        do_reset();
        rd_before = rd_data;
        chnl_in = {3'd0, 3'd2, 3'd1};
        req = 3'b011;
        tick();
        n = 0;
        ndone = 0;
        while (err == 3'b000 && n < 40) begin
            tick();
            n++;
            if (done != 3'b000) ndone++;
        end
        req = 3'b010;
        checks++;
        if (err !== 3'b001 || n != 17) begin
            errors++;
            $display("FAIL timeout_err got err=%b after %0d edges want 001 after 17", err, n);
        end
        checks++;
        if (ndone != 0 || rd_data !== rd_before || gnt !== 3'b000) begin
            errors++;
            $display("FAIL timeout_side got done_pulses=%0d rd=%h gnt=%b want 0/%h/000",
                     ndone, rd_data, gnt, rd_before);
        end
        tick();
        checks++;
        if (gnt !== 3'b010 || err !== 3'b000) begin
            errors++;
            $display("FAIL timeout_next got gnt=%b err=%b want 010/000", gnt, err);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_complete();
        test_reset_mid_wait();
        test_req_drop();
`ifdef A2D_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_arbiter.md
# a2d_arbiter

Round-robin arbiter that shares the single A2D SPI interface between three requesters: slide-pot scanner, volume/aux scanner and battery monitor. Each requester posts a 3-bit channel and a request. The arbiter grants one requester at a time and drives `strt_cnv`/`chnnl` to the A2D interface. It returns the 12-bit result to the granted requester with a one-cycle `done` pulse. It sits between the requester blocks and the A2D interface, and is the only driver of the converter's start/channel inputs.

## Interface
- `TIMEOUT`, default 1023: cycles spent in WAIT without `cnv_cmplt` before the conversion is aborted. Used only with `A2D_ARB_TIMEOUT_EN`. Legal range 1..1023.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `req`  in  3  per-requester request level; held high until the matching `done` or `err`
- `chnl_in`  in  9  requested channel: bits [3i+2:3i] belong to requester i; sampled only at grant
- `gnt`  out  3  one-hot grant; high from accept through completion
- `done`  out  3  one-hot, one-cycle pulse; `rd_data` is valid for that requester
- `err`  out  3  one-hot, one-cycle timeout pulse; constant 0 without the macro
- `rd_data`  out  12  last conversion result; holds value between completions
- `strt_cnv`  out  1  conversion start to the A2D interface
- `chnnl`  out  3  channel to the A2D interface
- `cnv_cmplt`  in  1  conversion complete from the A2D interface
- `res`  in  12  conversion result from the A2D interface

## Operation
- States:
  - IDLE: no grant.
  - START: one cycle; `strt_cnv` = 1.
  - WAIT: waiting for `cnv_cmplt`.
- IDLE, with `req` != 0:
  - Select the winner by round-robin, searching from `last+1` mod 3 upward. `last` is the most recently served requester; reset value 2, so requester 0 has first priority.
  - Latch `chnl_in` of the winner into `chnnl` and set its `gnt` bit.
  - Go to START.
- IDLE, with `req` == 0: stay in IDLE; all outputs hold.
- START:
  - `strt_cnv` = 1, decoded from state.
  - `cnv_cmplt` is ignored here, since a pulse in this cycle is stale.
  - Go to WAIT unconditionally.
- WAIT, with `cnv_cmplt` = 1:
  - `rd_data` <= `res`; `done[i]` <= 1 for one cycle; `gnt` <= 0; `last` <= i.
  - Go to IDLE.
- `chnnl` is held stable from grant until the state returns to IDLE.
- A `req` that drops while granted does not abort the conversion. The conversion completes, `done` still pulses, and the requester ignores it.
- A `req` still high in the IDLE cycle after its `done` is treated as a new request. It is then subject to round-robin, so the other requesters are served first.
- Reset values: state IDLE, `gnt` 0, `done` 0, `err` 0, `rd_data` 0, `chnnl` 0, `strt_cnv` 0, `last` 2, timeout counter 0.
- Reset during START or WAIT returns to IDLE immediately. No `done` or `err` is issued for the aborted conversion. The A2D interface shares `rst_n`.

## Timing
- `req` sampled high at edge N -> `gnt` and `chnnl` valid in cycle N+1, and `strt_cnv` is high for that cycle only.
- `cnv_cmplt` sampled high in WAIT at edge M -> in cycle M+1, `done` is high, `rd_data` is new and `gnt` is low.
- The earliest next grant is sampled at edge M+1, giving `gnt` in cycle M+2. Minimum issue-to-issue spacing is 2 cycles plus the conversion time.
- Arbiter overhead per conversion is 2 cycles: grant and completion.
- All outputs are registered except `strt_cnv`, which is decoded from the state register and is glitch-free.

## Configuration
- Macro: `A2D_ARB_TIMEOUT_EN`.
- Defined:
  - A 10-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches `TIMEOUT` without `cnv_cmplt`: `err[i]` pulses for one cycle, `gnt` <= 0, `last` <= i, state goes to IDLE, and `rd_data` is unchanged.
  - If `cnv_cmplt` and the timeout occur in the same cycle, completion wins.
- Undefined: WAIT holds indefinitely, `err` is tied to 0 and no counter is synthesized.

## Test plan
- Single request: `req`=001, `chnl_in`[2:0]=3'd4; the A2D model returns 12'hABC 40 cycles after `strt_cnv` -> `gnt`=001 and `chnnl`=4; one `strt_cnv` pulse; `done`=001 for 1 cycle; `rd_data`=12'hABC.
- Round-robin: all `req`=111 held, each requester re-requesting after its `done` -> grant order 0, 1, 2, 0, 1, 2; each `chnnl` matches that requester's `chnl_in` slice.
- Stale complete: `cnv_cmplt` pulsed during START -> ignored; the arbiter stays in WAIT until the real `cnv_cmplt`; exactly one `done`.
- Reset mid-WAIT: assert `rst_n`=0 twenty cycles into WAIT -> all outputs 0 immediately; after release with `req`=010, requester 1 is granted first.
- Timeout (macro defined, `TIMEOUT`=16): the model never completes -> `err`=the granted requester's bit, 16 cycles after entering WAIT; no `done`; `rd_data` unchanged; the next requester is granted.
- Request dropped mid-conversion: `req[2]` falls during WAIT -> conversion finishes; `done`=100; the arbiter returns to IDLE and does not re-grant requester 2.
